// File: rtl/cheri_tsmap_arbiter_pkg.sv
// Shared types for the temporal-safety map arbiter.
// Owner tags, clear-engine states and the default address width.
package cheri_tsmap_arbiter_pkg;

  localparam int TSMAP_AW = 16;

  typedef enum logic [2:0] {
    TSOWN_NONE,
    TSOWN_TRVK,
    TSOWN_BUS_RD,
    TSOWN_BUS_WR,
    TSOWN_CLR
  } tsmap_owner_e;

  typedef enum logic [1:0] {
    TSCLR_IDLE,
    TSCLR_RUN,
    TSCLR_DONE
  } tsmap_clr_state_e;

endpackage

// File: rtl/cheri_tsmap_clr_fsm.sv
// Background clear engine for the TSMAP.
// Walks [base, min(base+len, size)) one granted slot at a time.
module cheri_tsmap_clr_fsm
  import cheri_tsmap_arbiter_pkg::*;
#(
  parameter int TSMapSize = 1024,
  parameter int AddrW     = TSMAP_AW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AddrW-1:0] base_i,
  input  logic [AddrW:0]   len_i,
  input  logic             gnt_i,
  output logic             req_o,
  output logic [AddrW-1:0] addr_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [AddrW+1:0] SIZE_W = (AddrW+2)'(TSMapSize);

  tsmap_clr_state_e state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [AddrW:0]   end_q, end_d;
  logic [AddrW+1:0] sum;
  logic [AddrW:0]   lim;
  logic [AddrW:0]   ptr_nx;

  // Two guard bits keep base+len from wrapping.
  assign sum    = {2'b00, base_i} + {1'b0, len_i};
  assign lim    = (sum > SIZE_W) ? SIZE_W[AddrW:0]
                                 : sum[AddrW:0];
  assign ptr_nx = {1'b0, ptr_q} + (AddrW+1)'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    unique case (state_q)
      TSCLR_IDLE: begin
        if (start_i) begin
          ptr_d   = base_i;
          end_d   = lim;
          state_d = ({1'b0, base_i} >= lim) ? TSCLR_DONE
                                            : TSCLR_RUN;
        end
      end
      TSCLR_RUN: begin
        if (gnt_i) begin
          ptr_d = ptr_nx[AddrW-1:0];
          if (ptr_nx == end_q) state_d = TSCLR_DONE;
        end
      end
      TSCLR_DONE: state_d = TSCLR_IDLE;
      default:    state_d = TSCLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TSCLR_IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
    end
  end

  assign req_o  = (state_q == TSCLR_RUN);
  assign addr_o = ptr_q;
  assign busy_o = (state_q != TSCLR_IDLE);
  assign done_o = (state_q == TSCLR_DONE);

endmodule

// File: rtl/cheri_tsmap_arbiter.sv
// Single-port TSMAP SRAM owner shared by revocation reads,
// allocator bus accesses and the background clear engine.
module cheri_tsmap_arbiter
  import cheri_tsmap_arbiter_pkg::*;
#(
  parameter int TSMapSize = 1024,
  parameter int AddrW     = TSMAP_AW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trvk_cs_i,
  input  logic [AddrW-1:0] trvk_addr_i,
  output logic [31:0]      trvk_rdata_o,
  input  logic             bus_req_i,
  input  logic             bus_we_i,
  input  logic [AddrW-1:0] bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  input  logic [3:0]       bus_be_i,
  output logic             bus_gnt_o,
  output logic             bus_rvalid_o,
  output logic [31:0]      bus_rdata_o,
  output logic             bus_err_o,
  input  logic             clr_start_i,
  input  logic [AddrW-1:0] clr_base_i,
  input  logic [AddrW:0]   clr_len_i,
  output logic             clr_busy_o,
  output logic             clr_done_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_be_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam logic [AddrW:0] SIZE_A = (AddrW+1)'(TSMapSize);

  logic             clr_req;
  logic             clr_win;
  logic [AddrW-1:0] clr_addr;
  logic             trvk_go;
  logic             bus_win;
  logic             bus_oob;
  logic             prio_bus_q;
  logic             err_q, err_d;
  tsmap_owner_e     own_q, own_d;

  cheri_tsmap_clr_fsm #(
    .TSMapSize (TSMapSize),
    .AddrW     (AddrW)
  ) u_clr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (clr_start_i),
    .base_i  (clr_base_i),
    .len_i   (clr_len_i),
    .gnt_i   (clr_win),
    .req_o   (clr_req),
    .addr_o  (clr_addr),
    .busy_o  (clr_busy_o),
    .done_o  (clr_done_o)
  );

  // trvk always wins; prio_bus_q breaks bus/clear ties.
  assign trvk_go = rst_ni & trvk_cs_i;
  assign bus_oob = {1'b0, bus_addr_i} >= SIZE_A;
  assign bus_win = rst_ni & ~trvk_cs_i & bus_req_i
                 & (~clr_req | prio_bus_q);
  assign clr_win = rst_ni & ~trvk_cs_i & clr_req
                 & ~(bus_req_i & prio_bus_q);
  assign bus_gnt_o = bus_win;

  always_comb begin
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    own_d       = TSOWN_NONE;
    err_d       = 1'b0;
    unique case (1'b1)
      trvk_go: begin
        mem_cs_o   = 1'b1;
        mem_addr_o = trvk_addr_i;
        own_d      = TSOWN_TRVK;
      end
      bus_win: begin
        err_d = bus_oob;
        own_d = bus_we_i ? TSOWN_BUS_WR : TSOWN_BUS_RD;
        if (!bus_oob) begin
          mem_cs_o    = 1'b1;
          mem_we_o    = bus_we_i;
          mem_addr_o  = bus_addr_i;
          mem_be_o    = bus_be_i;
          mem_wdata_o = bus_we_i ? bus_wdata_i : '0;
        end
      end
      clr_win: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = clr_addr;
        mem_be_o   = 4'hF;
        own_d      = TSOWN_CLR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      own_q      <= TSOWN_NONE;
      err_q      <= 1'b0;
      prio_bus_q <= 1'b1;
    end else begin
      own_q <= own_d;
      err_q <= err_d;
      if (bus_win)      prio_bus_q <= 1'b0;
      else if (clr_win) prio_bus_q <= 1'b1;
    end
  end

  assign trvk_rdata_o = (own_q == TSOWN_TRVK) ? mem_rdata_i
                                              : '0;
  assign bus_rvalid_o = (own_q == TSOWN_BUS_RD)
                      | (own_q == TSOWN_BUS_WR);
  assign bus_err_o    = bus_rvalid_o & err_q;
  assign bus_rdata_o  = (own_q == TSOWN_BUS_RD && !err_q)
                      ? mem_rdata_i : '0;

endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// Randomised and directed bench for cheri_tsmap_arbiter.
// Reference model tracks map contents and arbitration rules.
module tb_cheri_tsmap_arbiter;

  localparam int SZ = 1024;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          trvk_cs;
  logic [AW-1:0] trvk_addr;
  logic [31:0]   trvk_rdata;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_gnt, bus_rvalid, bus_err;
  logic [31:0]   bus_rdata;
  logic          clr_start;
  logic [AW-1:0] clr_base;
  logic [AW:0]   clr_len;
  logic          clr_busy, clr_done;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  always #5 clk_i = ~clk_i;

  cheri_tsmap_arbiter #(
    .TSMapSize (SZ),
    .AddrW     (AW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .trvk_cs_i    (trvk_cs),
    .trvk_addr_i  (trvk_addr),
    .trvk_rdata_o (trvk_rdata),
    .bus_req_i    (bus_req),
    .bus_we_i     (bus_we),
    .bus_addr_i   (bus_addr),
    .bus_wdata_i  (bus_wdata),
    .bus_be_i     (bus_be),
    .bus_gnt_o    (bus_gnt),
    .bus_rvalid_o (bus_rvalid),
    .bus_rdata_o  (bus_rdata),
    .bus_err_o    (bus_err),
    .clr_start_i  (clr_start),
    .clr_base_i   (clr_base),
    .clr_len_i    (clr_len),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done),
    .mem_cs_o     (mem_cs),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_rdata_i  (mem_rdata)
  );

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] nw,
    input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SRAM with one-cycle read latency
  logic [31:0] sram [SZ];
  initial begin
    for (int i = 0; i < SZ; i++) sram[i] = '0;
    forever begin
      @(posedge clk_i);
      if (mem_cs && int'(mem_addr) < SZ) begin
        if (mem_we)
          sram[mem_addr] <= merge(sram[mem_addr],
                                  mem_wdata, mem_be);
        else
          mem_rdata <= sram[mem_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] exp_mem [SZ];
  int  m_st;
  int  m_ptr, m_end;
  bit  m_pbus;
  bit  p_trvk, p_bus, p_rd, p_err;
  logic [31:0] p_data;
  int  wr_cnt, done_cnt;

  task automatic model_reset();
    m_st   = 0;
    m_pbus = 1;
    p_trvk = 0;
    p_bus  = 0;
  endtask

  task automatic cyc();
    bit g_bus, g_clr, e_cs, e_we, oob;
    int e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    @(negedge clk_i);
    chk("trvk_rdata", trvk_rdata, p_trvk ? p_data : 32'h0);
    chk("bus_rvalid", bus_rvalid, p_bus);
    chk("bus_err", bus_err, p_bus && p_err);
    chk("bus_rdata", bus_rdata,
        (p_bus && p_rd && !p_err) ? p_data : 32'h0);
    chk("clr_busy", clr_busy, m_st != 0);
    chk("clr_done", clr_done, m_st == 2);
    if (clr_done === 1'b1) done_cnt++;
    if (mem_cs === 1'b1 && mem_we === 1'b1) wr_cnt++;
    if (mem_cs === 1'b1)
      chk("mem_range", int'(mem_addr) < SZ, 1);
    oob = int'(bus_addr) >= SZ;
    g_bus = 0; g_clr = 0; e_cs = 0; e_we = 0;
    e_addr = 0; e_wd = '0; e_be = '0;
    if (rst_ni) begin
      if (trvk_cs) begin
        e_cs = 1; e_addr = int'(trvk_addr);
      end else begin
        g_bus = bus_req && (m_st != 1 || m_pbus);
        g_clr = (m_st == 1) && !g_bus;
        if (g_bus && !oob) begin
          e_cs = 1; e_we = bus_we; e_addr = int'(bus_addr);
          if (bus_we) begin e_wd = bus_wdata; e_be = bus_be; end
        end
        if (g_clr) begin
          e_cs = 1; e_we = 1; e_addr = m_ptr; e_be = 4'hF;
        end
      end
    end
    chk("bus_gnt", bus_gnt, g_bus);
    chk("mem_cs", mem_cs, e_cs);
    if (e_cs) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) begin
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_be", mem_be, e_be);
      end
    end
    if (!rst_ni) model_reset();
    else begin
      p_trvk = trvk_cs;
      p_bus  = g_bus;
      p_rd   = !bus_we;
      p_err  = oob;
      p_data = '0;
      if (trvk_cs) p_data = exp_mem[trvk_addr];
      else if (g_bus && !oob && !bus_we)
        p_data = exp_mem[bus_addr];
      if (g_bus && !oob && bus_we)
        exp_mem[bus_addr] = merge(exp_mem[bus_addr],
                                  bus_wdata, bus_be);
      if (g_bus) m_pbus = 0;
      if (g_clr) m_pbus = 1;
      case (m_st)
        0: if (clr_start) begin
          m_ptr = int'(clr_base);
          m_end = int'(clr_base) + int'(clr_len);
          if (m_end > SZ) m_end = SZ;
          m_st = (m_ptr >= m_end) ? 2 : 1;
        end
        1: if (g_clr) begin
          exp_mem[m_ptr] = '0;
          m_ptr++;
          if (m_ptr == m_end) m_st = 2;
        end
        default: m_st = 0;
      endcase
    end
    @(posedge clk_i);
    #1;
    trvk_cs   = 0;
    clr_start = 0;
    if (g_bus) bus_req = 0;
  endtask

  task automatic bus_put(input bit we, input int addr,
                         input logic [31:0] wd,
                         input logic [3:0] be);
    bus_req   = 1;
    bus_we    = we;
    bus_addr  = AW'(addr);
    bus_wdata = wd;
    bus_be    = be;
  endtask

  task automatic clr_go(input int base, input int len);
    clr_start = 1;
    clr_base  = AW'(base);
    clr_len   = (AW+1)'(len);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (m_st != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
  endtask

  initial begin
    for (int i = 0; i < SZ; i++) exp_mem[i] = '0;
    rst_ni = 0; trvk_cs = 0; trvk_addr = '0;
    bus_req = 0; bus_we = 0; bus_addr = '0;
    bus_wdata = '0; bus_be = '0;
    clr_start = 0; clr_base = '0; clr_len = '0;
    model_reset();
    wr_cnt = 0; done_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", clr_busy, 0);
    chk("rst_rvalid", bus_rvalid, 0);
    chk("rst_trvk", trvk_rdata, 0);
    rst_ni = 1;
    cyc();

    // bus write then read back
    bus_put(1, 5, 32'hA5A5_0001, 4'hF);
    cyc();
    chk("t1_wr_rvalid", bus_rvalid, 1);
    bus_put(0, 5, '0, 4'hF);
    cyc();
    chk("t1_rd_data", bus_rdata, 32'hA5A5_0001);
    chk("t1_rd_err", bus_err, 0);

    // trvk collides with bus on word 7
    bus_put(1, 7, 32'h0000_7777, 4'hF);
    cyc();
    trvk_cs = 1; trvk_addr = 7;
    bus_put(0, 7, '0, 4'hF);
    cyc();
    chk("t2_trvk_data", trvk_rdata, 32'h0000_7777);
    chk("t2_bus_held", bus_req, 1);
    cyc();
    chk("t2_bus_data", bus_rdata, 32'h0000_7777);

    // clear against a continuously requesting bus
    for (int a = 10; a < 14; a++) begin
      bus_put(1, a, 32'hDEAD_0000 + a, 4'hF);
      cyc();
    end
    done_cnt = 0;
    clr_go(10, 4);
    cyc();
    for (int n = 0; n < 40 && m_st != 0; n++) begin
      if (!bus_req)
        bus_put(1, 20 + n % 8, $urandom, 4'hF);
      cyc();
    end
    chk("t3_finished", m_st, 0);
    cyc();
    chk("t3_done_once", done_cnt, 1);
    chk("t3_busy_clear", clr_busy, 0);
    for (int a = 10; a < 14; a++) begin
      bus_put(0, a, '0, 4'hF);
      cyc();
      chk("t3_word_zero", bus_rdata, 0);
    end

    // clear clipped at the top of the map
    cyc();
    wr_cnt = 0; done_cnt = 0;
    clr_go(SZ - 2, 8);
    repeat (8) cyc();
    chk("t4_writes", wr_cnt, 2);
    chk("t4_done", done_cnt, 1);

    // out-of-range bus read
    bus_put(0, SZ, '0, 4'hF);
    cyc();
    chk("t5_err", bus_err, 1);
    chk("t5_rdata", bus_rdata, 0);

    // zero-length clear
    done_cnt = 0;
    clr_go(3, 0);
    repeat (3) cyc();
    chk("t5b_done", done_cnt, 1);

    // reset in the middle of a clear
    clr_go(100, 16);
    repeat (3) cyc();
    rst_ni = 0;
    cyc();
    rst_ni = 1;
    chk("t6_busy", clr_busy, 0);
    wr_cnt = 0; done_cnt = 0;
    repeat (20) cyc();
    chk("t6_no_writes", wr_cnt, 0);
    chk("t6_no_done", done_cnt, 0);
    clr_go(200, 2);
    cyc();
    wait_done("t6_restart", 20);
    chk("t6_restart_done", done_cnt, 1);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        trvk_cs = 1;
        trvk_addr = AW'($urandom_range(0, 31));
      end
      if (!bus_req && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 7) == 0)
          bus_put($urandom_range(0, 1),
                  $urandom_range(SZ - 4, SZ + 3),
                  $urandom, 4'($urandom));
        else
          bus_put($urandom_range(0, 1),
                  $urandom_range(0, 31),
                  $urandom, 4'($urandom));
      end
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0)
          clr_go($urandom_range(SZ - 6, SZ + 2),
                 $urandom_range(0, 12));
        else
          clr_go($urandom_range(0, 30),
                 $urandom_range(0, 12));
      end
      rst_ni = ($urandom_range(0, 499) != 0);
      cyc();
      rst_ni = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
